// File: rtl/result_line_packer.sv
// result_line_packer: packs 32-bit result words LSB-first into 512-bit lines,
// buffers them in a line FIFO and releases paced bursts to the result BRAM writer.
module result_line_packer #(
   parameter int WORD_WIDTH      = 32,
   parameter int LINE_WIDTH      = 512,
   parameter int FIFO_LINES      = 8,
   parameter int LINES_PER_BURST = 4,
   parameter int LINE_SPACING    = 17
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          en_i,
   input  logic                          in_valid_i,
   input  logic [WORD_WIDTH-1:0]         in_data_i,
   input  logic                          in_last_i,
   output logic                          in_ready_o,
   input  logic                          req_i,
   output logic                          valid_o,
   output logic [LINE_WIDTH-1:0]         data_o,
   output logic                          waiting_o,
   output logic                          ready_o,
   output logic [$clog2(FIFO_LINES):0]   lines_o,
   output logic                          overflow_o
);
   localparam int WORDS = LINE_WIDTH / WORD_WIDTH;
   localparam int IW    = $clog2(WORDS);
   localparam int PW    = $clog2(FIFO_LINES);
   localparam int CW    = PW + 1;
   localparam int GW    = $clog2(LINE_SPACING);
   localparam int SW    = $clog2(LINES_PER_BURST + 1);

   typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

   state_t                state, state_d;
   logic [LINE_WIDTH-1:0] asm_q, line_d, hold_q, head;
   logic [LINE_WIDTH-1:0] mem [FIFO_LINES];
   logic [IW-1:0]         idx;
   logic [PW-1:0]         wr_ptr, rd_ptr;
   logic [CW-1:0]         count;
   logic [GW-1:0]         gap_cnt, gap_d;
   logic [SW-1:0]         sent, sent_d;
   logic                  live, flush, accept, push, pop, leave;

   // live keeps in_ready_o low while reset is held, whatever en_i does
   assign in_ready_o = live && en_i && count < CW'(FIFO_LINES);
   assign accept     = in_valid_i && in_ready_o;
   assign push       = accept && (in_last_i || idx == IW'(WORDS - 1));
   assign valid_o    = state == SEND;
   assign pop        = valid_o && count != '0;
   assign head       = count != '0 ? mem[rd_ptr] : '0;
   assign data_o     = valid_o ? head : hold_q;
   assign ready_o    = en_i && state == IDLE &&
                       (count >= CW'(LINES_PER_BURST) || (flush && count != '0));
   assign waiting_o  = !ready_o;
   assign lines_o    = count;

   always_comb begin
      line_d = asm_q;
      for (int k = 0; k < WORDS; k++)
         if (idx == IW'(k)) line_d[k*WORD_WIDTH +: WORD_WIDTH] = in_data_i;
   end

   always_ff @(posedge clk_i or negedge rst_i)
      if (!rst_i) begin
         live       <= 1'b0;
         asm_q      <= '0;
         idx        <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         hold_q     <= '0;
         flush      <= 1'b0;
         overflow_o <= 1'b0;
      end else begin
         live <= 1'b1;
         if (accept) begin
            asm_q <= push ? '0 : line_d;
            idx   <= push ? '0 : idx + 1'b1;
         end
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
         if (valid_o) hold_q <= head;
         flush <= (accept && in_last_i) || (flush && !(leave && count == '0));
         if (in_valid_i && !in_ready_o) overflow_o <= 1'b1;
      end

   always_ff @(posedge clk_i)
      if (push) mem[wr_ptr] <= line_d;

   always_ff @(posedge clk_i or negedge rst_i)
      if (!rst_i) begin
         state   <= IDLE;
         gap_cnt <= '0;
         sent    <= '0;
      end else begin
         state   <= state_d;
         gap_cnt <= gap_d;
         sent    <= sent_d;
      end

   always_comb begin
      state_d = state;
      gap_d   = gap_cnt;
      sent_d  = sent;
      leave   = 1'b0;
      case (state)
         IDLE: state_d = req_i && ready_o ? SEND : IDLE;
         SEND: begin
            sent_d  = sent + 1'b1;
            state_d = GAP;
         end
         GAP:
            if (gap_cnt == GW'(LINE_SPACING - 2)) begin
               gap_d   = '0;
               leave   = sent >= SW'(LINES_PER_BURST);
               sent_d  = leave ? '0 : sent;
               state_d = leave ? IDLE : SEND;
            end else
               gap_d = gap_cnt + 1'b1;
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_result_line_packer.sv
// tb_result_line_packer: directed bench for result_line_packer with hand-derived
// line contents and valid_o timing.
module tb_result_line_packer;
   localparam int WW = 32;
   localparam int LW = 512;

   logic          clk = 0, rst = 1, en = 1, in_valid = 0, in_last = 0, req = 0;
   logic [WW-1:0] in_data = '0;
   logic          in_ready, valid, waiting, ready, overflow;
   logic [LW-1:0] data;
   logic [3:0]    lines;

   result_line_packer dut (
      .clk_i(clk), .rst_i(rst), .en_i(en), .in_valid_i(in_valid), .in_data_i(in_data),
      .in_last_i(in_last), .in_ready_o(in_ready), .req_i(req), .valid_o(valid),
      .data_o(data), .waiting_o(waiting), .ready_o(ready), .lines_o(lines),
      .overflow_o(overflow)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [LW-1:0] q[$];
   int            tq[$];
   always @(negedge clk)
      if (valid) begin
         q.push_back(data);
         tq.push_back(cyc);
      end

   int total = 0, bad = 0;

   task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [LW-1:0] mk_line(input int base, input int n);
      logic [LW-1:0] l = '0;
      for (int j = 0; j < n; j++) l[j*WW +: WW] = WW'(base + j);
      return l;
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic send(input int v, input bit last);
      in_valid = 1; in_data = WW'(v); in_last = last;
      tick();
      in_valid = 0; in_last = 0;
   endtask

   task automatic send_n(input int base, input int n);
      for (int i = 0; i < n; i++) send(base + i, 0);
   endtask

   task automatic pulse_req();
      req = 1;
      tick();
      req = 0;
   endtask

   task automatic do_reset();
      rst = 0;
      #1;
      check("rst_in_ready", in_ready, 0);
      check("rst_valid", valid, 0);
      check("rst_data", data, 0);
      check("rst_waiting", waiting, 1);
      check("rst_ready", ready, 0);
      check("rst_lines", lines, 0);
      check("rst_overflow", overflow, 0);
      tick(); tick();
      rst = 1;
      tick(); tick();
   endtask

   int c;

   initial begin
      #2;
      // full burst of four packed lines
      do_reset();
      send_n(0, 64);
      check("t1_lines_pre", lines, 4);
      check("t1_ready_pre", ready, 1);
      q.delete(); tq.delete();
      c = cyc;
      pulse_req();
      repeat (60) tick();
      check("t1_count", q.size(), 4);
      if (q.size() == 4)
         for (int k = 0; k < 4; k++) begin
            check($sformatf("t1_time%0d", k), tq[k] - c, 1 + 17 * k);
            check($sformatf("t1_line%0d", k), q[k], mk_line(16 * k, 16));
         end
      check("t1_lines_post", lines, 0);
      check("t1_waiting_post", waiting, 1);

      // three lines without last: request ignored
      do_reset();
      send_n(0, 48);
      check("t4_lines", lines, 3);
      check("t4_waiting_pre", waiting, 1);
      q.delete();
      pulse_req();
      repeat (30) tick();
      check("t4_no_valid", q.size(), 0);
      check("t4_waiting_post", waiting, 1);
      check("t4_lines_post", lines, 3);

      // partial line flush with zero-filled padding lines
      do_reset();
      send_n(100, 19);
      send(119, 1);
      check("t2_lines_pre", lines, 2);
      check("t2_ready_pre", ready, 1);
      q.delete();
      pulse_req();
      repeat (70) tick();
      check("t2_count", q.size(), 4);
      if (q.size() == 4) begin
         check("t2_line0", q[0], mk_line(100, 16));
         check("t2_line1", q[1], mk_line(116, 4));
         check("t2_line2", q[2], 0);
         check("t2_line3", q[3], 0);
      end
      check("t2_ready_post", ready, 0);
      check("t2_lines_post", lines, 0);

      // FIFO full, overflow, dropped words leave contents intact
      do_reset();
      for (int i = 0; i < 136; i++) begin
         if (i == 128) begin
            check("t3_in_ready_full", in_ready, 0);
            check("t3_lines_full", lines, 8);
            check("t3_ovf_before", overflow, 0);
         end
         if (i == 129) check("t3_ovf_after", overflow, 1);
         send(i, 0);
      end
      check("t3_lines_end", lines, 8);
      q.delete();
      pulse_req();
      repeat (70) tick();
      check("t3_count", q.size(), 4);
      if (q.size() == 4) begin
         check("t3_line0", q[0], mk_line(0, 16));
         check("t3_line3", q[3], mk_line(48, 16));
      end
      check("t3_lines_post", lines, 4);
      check("t3_ovf_sticky", overflow, 1);

      // push coinciding with pop, then pointer wrap
      do_reset();
      send_n(0, 64);
      q.delete();
      for (int k = 0; k < 67; k++) begin
         req = (k == 0);
         in_valid = (k >= 3);
         in_data = WW'(64 + k - 3);
         if (k == 18) begin
            check("t5_valid_coincide", valid, 1);
            check("t5_lines_before", lines, 3);
         end
         if (k == 19) check("t5_lines_after", lines, 3);
         tick();
      end
      req = 0; in_valid = 0;
      repeat (5) tick();
      check("t5_lines_mid", lines, 4);
      send_n(128, 64);
      check("t5_lines_full", lines, 8);
      pulse_req();
      repeat (70) tick();
      pulse_req();
      repeat (70) tick();
      check("t5_count", q.size(), 12);
      if (q.size() == 12)
         for (int n = 0; n < 12; n++)
            check($sformatf("t5_line%0d", n), q[n], mk_line(16 * n, 16));
      check("t5_lines_post", lines, 0);

      // reset mid-burst aborts it
      do_reset();
      send_n(0, 64);
      q.delete();
      pulse_req();
      repeat (25) tick();
      check("t6_two_seen", q.size(), 2);
      do_reset();
      repeat (60) tick();
      check("t6_no_more", q.size(), 2);
      check("t6_lines", lines, 0);
      check("t6_waiting", waiting, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
